alu_mdu: RTL and testbench



---
 rtl/alu_mdu.sv | 210 +++++++++++++++++++++
 tb/tb_alu_mdu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Brief    : EX-stage ALU with a multi-cycle multiply/divide unit that owns
//             the HI/LO register pair. Combinational ops resolve in the same
//             cycle. MD ops hold ALU_Busy high for a fixed cycle count.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALU_Operand1,
  input  logic [WIDTH-1:0] ALU_Operand2,
  input  logic [4:0]       ALU_Operation,
  input  logic             ALU_Start,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             ALU_isZero,
  output logic             ALU_Overflow,
  output logic             ALU_Busy,
  output logic [WIDTH-1:0] ALU_HI,
  output logic [WIDTH-1:0] ALU_LO
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // Counter only ever holds N-1, so clog2(N) bits are enough.
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_OR    = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MTHI  = 5'd20;
  localparam logic [4:0] OP_MTLO  = 5'd21;
  localparam logic [4:0] OP_MFHI  = 5'd22;
  localparam logic [4:0] OP_MFLO  = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] op_a, op_a_next;
  logic [WIDTH-1:0] op_b, op_b_next;
  logic             md_signed, md_signed_next;
  logic [WIDTH-1:0] hi, hi_next;
  logic [WIDTH-1:0] lo, lo_next;

  // ---------------------------------------------------------------- ALU ---
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   shamt;

  assign add_ext = {ALU_Operand1[WIDTH-1], ALU_Operand1} + {ALU_Operand2[WIDTH-1], ALU_Operand2};
  assign sub_ext = {ALU_Operand1[WIDTH-1], ALU_Operand1} - {ALU_Operand2[WIDTH-1], ALU_Operand2};
  assign shamt   = ALU_Operand1[SHW-1:0];

  // Combinational result mux; overflow only meaningful for ADD/SUB.
  always_comb begin
    ALU_Result   = '0;
    ALU_Overflow = 1'b0;
    case (ALU_Operation)
      OP_ADD: begin
        ALU_Result   = add_ext[WIDTH-1:0];
        ALU_Overflow = add_ext[WIDTH] ^ add_ext[WIDTH-1];
      end
      OP_SUB: begin
        ALU_Result   = sub_ext[WIDTH-1:0];
        ALU_Overflow = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
      end
      OP_OR:   ALU_Result = ALU_Operand1 | ALU_Operand2;
      OP_AND:  ALU_Result = ALU_Operand1 & ALU_Operand2;
      OP_XOR:  ALU_Result = ALU_Operand1 ^ ALU_Operand2;
      OP_NOR:  ALU_Result = ~(ALU_Operand1 | ALU_Operand2);
      OP_SLT:  ALU_Result = {{(WIDTH-1){1'b0}}, ($signed(ALU_Operand1) < $signed(ALU_Operand2))};
      OP_SLTU: ALU_Result = {{(WIDTH-1){1'b0}}, (ALU_Operand1 < ALU_Operand2)};
      OP_SLL:  ALU_Result = ALU_Operand2 << shamt;
      OP_SRL:  ALU_Result = ALU_Operand2 >> shamt;
      OP_SRA:  ALU_Result = $signed(ALU_Operand2) >>> shamt;
      OP_MFHI: ALU_Result = hi;
      OP_MFLO: ALU_Result = lo;
      default: ALU_Result = '0;
    endcase
  end

  assign ALU_isZero = (ALU_Result == '0);
  assign ALU_Busy   = (state != S_IDLE);
  assign ALU_HI     = hi;
  assign ALU_LO     = lo;

  // ------------------------------------------------------- multiply/divide ---
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic               a_neg, b_neg, div_by_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, div_quo, div_rem;

  assign mul_a_ext = md_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
  assign mul_b_ext = md_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;

  // Signed division via magnitudes. MIN_NEG / -1 falls out naturally:
  // |MIN_NEG| = MIN_NEG as unsigned, negating it again yields MIN_NEG, rem 0.
  assign a_neg       = md_signed & op_a[WIDTH-1];
  assign b_neg       = md_signed & op_b[WIDTH-1];
  assign a_mag       = a_neg ? -op_a : op_a;
  assign b_mag       = b_neg ? -op_b : op_b;
  assign div_by_zero = (op_b == '0);
  assign b_safe      = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag       = a_mag / b_safe;
  assign r_mag       = a_mag % b_safe;
  assign div_quo     = div_by_zero ? '1   : ((a_neg ^ b_neg) ? -q_mag : q_mag);
  assign div_rem     = div_by_zero ? op_a : (a_neg ? -r_mag : r_mag);

  // MD controller next-state: accept starts only in IDLE, count down, commit HI/LO.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    op_a_next      = op_a;
    op_b_next      = op_b;
    md_signed_next = md_signed;
    hi_next        = hi;
    lo_next        = lo;
    case (state)
      S_IDLE: begin
        if (ALU_Start) begin
          case (ALU_Operation)
            OP_MULT, OP_MULTU: begin
              state_next     = S_MULT;
              cnt_next       = MULT_LOAD;
              op_a_next      = ALU_Operand1;
              op_b_next      = ALU_Operand2;
              md_signed_next = (ALU_Operation == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_next     = S_DIV;
              cnt_next       = DIV_LOAD;
              op_a_next      = ALU_Operand1;
              op_b_next      = ALU_Operand2;
              md_signed_next = (ALU_Operation == OP_DIV);
            end
            OP_MTHI: hi_next = ALU_Operand1;
            OP_MTLO: lo_next = ALU_Operand1;
            default: ;
          endcase
        end
      end
      S_MULT: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          {hi_next, lo_next} = mul_prod;
          state_next         = S_IDLE;
        end
      end
      S_DIV: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          hi_next    = div_rem;
          lo_next    = div_quo;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // MD state registers; async reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      md_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      op_a      <= op_a_next;
      op_b      <= op_b_next;
      md_signed <= md_signed_next;
      hi        <= hi_next;
      lo        <= lo_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mdu
//  Brief    : Directed self-checking bench for alu_mdu (32-bit and 16-bit
//             instances) with a queue-based scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

  logic        clk;
  logic        rst;

  logic [31:0] a, b, result, hi, lo;
  logic [4:0]  op;
  logic        start, is_zero, ovf, busy;

  logic [15:0] a16, b16, result16, hi16, lo16;
  logic [4:0]  op16;
  logic        start16, is_zero16, ovf16, busy16;

  alu_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
    .clk(clk), .reset(rst),
    .ALU_Operand1(a), .ALU_Operand2(b), .ALU_Operation(op), .ALU_Start(start),
    .ALU_Result(result), .ALU_isZero(is_zero), .ALU_Overflow(ovf),
    .ALU_Busy(busy), .ALU_HI(hi), .ALU_LO(lo)
  );

  alu_mdu #(.WIDTH(16), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut16 (
    .clk(clk), .reset(rst),
    .ALU_Operand1(a16), .ALU_Operand2(b16), .ALU_Operation(op16), .ALU_Start(start16),
    .ALU_Result(result16), .ALU_isZero(is_zero16), .ALU_Overflow(ovf16),
    .ALU_Busy(busy16), .ALU_HI(hi16), .ALU_LO(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a combinational op on the 32-bit DUT and check result/flags.
  task automatic comb32(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ez, input logic eo);
    push_exp({tag, "_result"}, er);
    push_exp({tag, "_zero"}, {31'd0, ez});
    push_exp({tag, "_ovf"}, {31'd0, eo});
    op = o; a = x; b = y;
    #1;
    pop_check(result);
    pop_check({31'd0, is_zero});
    pop_check({31'd0, ovf});
  endtask

  task automatic wait_idle32(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle16(output int n);
    n = 0;
    while (busy16 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Full MD operation on the 32-bit DUT: expectations queued at start.
  task automatic md32(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int ecyc, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    push_exp({tag, "_cycles"}, ecyc);
    push_exp({tag, "_hi"}, ehi);
    push_exp({tag, "_lo"}, elo);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; op = 5'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    wait_idle32(n);
    pop_check(n);
    pop_check(hi);
    pop_check(lo);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = 5'd0; a = '0; b = '0;
    start16 = 1'b0; op16 = 5'd0; a16 = '0; b16 = '0;
    tick();
    tick();
    cmp("reset_busy", {31'd0, busy}, 32'd0);
    cmp("reset_hi", hi, 32'd0);
    cmp("reset_lo", lo, 32'd0);
    rst = 1'b0;
    tick();

    // Combinational ALU
    comb32("add_ovf",  5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    comb32("sub_zero", 5'd1,  32'd5,         32'd5,         32'd0,         1'b1, 1'b0);
    comb32("sub_ovf",  5'd1,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1);
    comb32("or",       5'd2,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
    comb32("and",      5'd3,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0);
    comb32("xor",      5'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
    comb32("nor",      5'd5,  32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0, 1'b0, 1'b0);
    comb32("slt",      5'd6,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0);
    comb32("sltu",     5'd7,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0);
    comb32("sll",      5'd8,  32'd36,        32'h0000_0003, 32'h0000_0030, 1'b0, 1'b0);
    comb32("srl",      5'd9,  32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0);
    comb32("sra",      5'd10, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
    comb32("undef",    5'd11, 32'h1234_5678, 32'h1,         32'd0,         1'b1, 1'b0);
    comb32("md_noop",  5'd16, 32'h1234_5678, 32'h2,         32'd0,         1'b1, 1'b0);
    tick();
    cmp("no_start_busy", {31'd0, busy}, 32'd0);

    // MTLO, then MULT while MFLO must still show the old LO
    op = 5'd21; a = 32'hAAAA_5555; start = 1'b1;
    tick();
    start = 1'b0;
    comb32("mflo_mtlo", 5'd23, 32'd0, 32'd0, 32'hAAAA_5555, 1'b0, 1'b0);

    push_exp("mult_cycles", 32'd5);
    push_exp("mult_hi", 32'hFFFF_FFFF);
    push_exp("mult_lo", 32'hFFFF_FFEB);
    op = 5'd16; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = 5'd23; a = 32'h1234_5678; b = 32'd9;
    #1;
    cmp("mult_busy_now", {31'd0, busy}, 32'd1);
    cmp("mflo_old_during_busy", result, 32'hAAAA_5555);
    cmp("lo_held_during_busy", lo, 32'hAAAA_5555);
    wait_idle32(n);
    pop_check(n);
    pop_check(hi);
    pop_check(lo);
    op = 5'd22; #1;
    cmp("mfhi_after_mult", result, 32'hFFFF_FFFF);

    // Division and its boundaries
    md32("div_neg",   5'd18, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md32("divu_zero", 5'd19, 32'd7,         32'd0,         10, 32'd7,         32'hFFFF_FFFF);
    md32("div_zero",  5'd18, 32'hFFFF_FFF9, 32'd0,         10, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    md32("div_minm1", 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
    md32("divu_big",  5'd19, 32'hFFFF_FFF9, 32'd2,         10, 32'd1,         32'h7FFF_FFFC);
    md32("multu",     5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'd1);

    // Starts while busy are ignored
    push_exp("ign_cycles", 32'd10);
    push_exp("ign_hi", 32'd2);
    push_exp("ign_lo", 32'd14);
    op = 5'd18; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    op = 5'd17; a = 32'd3; b = 32'd3; start = 1'b1;
    tick();
    op = 5'd20; a = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0; op = 5'd0;
    wait_idle32(n);
    pop_check(n + 4);
    pop_check(hi);
    pop_check(lo);

    // Async reset mid-DIV
    op = 5'd19; a = 32'd50; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    cmp("rst_mid_busy", {31'd0, busy}, 32'd0);
    cmp("rst_mid_hi", hi, 32'd0);
    cmp("rst_mid_lo", lo, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    cmp("post_rst_busy", {31'd0, busy}, 32'd0);
    op = 5'd21; a = 32'h0000_1234; start = 1'b1;
    tick();
    start = 1'b0;
    comb32("mflo_after_rst", 5'd23, 32'd0, 32'd0, 32'h0000_1234, 1'b0, 1'b0);
    comb32("mfhi_after_rst", 5'd22, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // 16-bit instance
    op16 = 5'd6; a16 = 16'h8000; b16 = 16'h0001; #1;
    cmp("slt16", {16'd0, result16}, 32'd1);
    op16 = 5'd7; #1;
    cmp("sltu16", {16'd0, result16}, 32'd0);
    cmp("sltu16_zero", {31'd0, is_zero16}, 32'd1);
    op16 = 5'd0; a16 = 16'h7FFF; b16 = 16'h0001; #1;
    cmp("add16_ovf", {31'd0, ovf16}, 32'd1);
    tick();
    push_exp("multu16_cycles", 32'd5);
    push_exp("multu16_hi", 32'h0000_FFFE);
    push_exp("multu16_lo", 32'h0000_0001);
    op16 = 5'd17; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    tick();
    start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    wait_idle16(n);
    pop_check(n);
    pop_check({16'd0, hi16});
    pop_check({16'd0, lo16});

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
